// File: rtl/banked_read_sram.sv
// Multi-port read memory built from NBANK single-read banks, with per-bank arbitration and same-row broadcast.
// Optional feature macro BANKSRAM_WRITE_BYPASS_EN forwards same-cycle write data to matching pending reads.
module banked_read_sram #(
  parameter int NPORT = 4,
  parameter int NBANK = 8,
  parameter int WIDTH = 72,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   i_fire,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic [AW-1:0]          i_writeAddr,
  input  logic [WIDTH-1:0]       i_writeData,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [NPORT*AW-1:0]    i_readAddr,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [NPORT*WIDTH-1:0] o_datas,
  output logic [15:0]            o_conflict_cnt
);
  localparam int BW   = $clog2(NBANK);
  localparam int RW   = AW - BW;
  localparam int ROWS = DEPTH / NBANK;

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t                 state;
  logic [NPORT-1:0]       pending;
  logic [NPORT*AW-1:0]    addr_q;
  logic [NPORT*WIDTH-1:0] data_q;
  logic                   rsp_valid_q;
  logic [15:0]            conflict_q;

  logic [WIDTH-1:0] mem [NBANK][ROWS];

  logic             accept;
  logic [NPORT-1:0] eff_pend;
  logic [AW-1:0]    eff_addr [NPORT];
  logic [BW-1:0]    port_bank [NPORT];
  logic [RW-1:0]    port_row [NPORT];
  logic [BW-1:0]    wr_bank;
  logic [RW-1:0]    wr_row;
  logic [NBANK-1:0] bank_busy;
  logic [NBANK-1:0] win_valid;
  logic [RW-1:0]    win_row [NBANK];
  logic [WIDTH-1:0] bank_rdata [NBANK];
  logic [NPORT-1:0] fwd;
  logic [NPORT-1:0] served;
  logic [WIDTH-1:0] served_data [NPORT];
  logic [NPORT-1:0] remaining;

  assign o_req_ready    = (state == IDLE) || (state == DONE && i_rsp_ready);
  assign accept         = i_req_valid && o_req_ready;
  assign wr_bank        = i_writeAddr[BW-1:0];
  assign wr_row         = i_writeAddr[AW-1:BW];
  assign o_rsp_valid    = rsp_valid_q;
  assign o_datas        = data_q;
  assign o_conflict_cnt = conflict_q;

  // Service starts in the acceptance cycle, so the incoming bundle bypasses the address latch.
  always_comb begin
    eff_pend = accept ? {NPORT{1'b1}} : pending;
    for (int p = 0; p < NPORT; p++) begin
      eff_addr[p]  = accept ? i_readAddr[p*AW +: AW] : addr_q[p*AW +: AW];
      port_bank[p] = eff_addr[p][BW-1:0];
      port_row[p]  = eff_addr[p][AW-1:BW];
    end
  end

  always_comb begin
    bank_busy = '0;
    if (write_en) bank_busy[wr_bank] = 1'b1;
  end

  always_comb begin
    fwd = '0;
`ifdef BANKSRAM_WRITE_BYPASS_EN
    for (int p = 0; p < NPORT; p++)
      fwd[p] = eff_pend[p] && write_en && (eff_addr[p] == i_writeAddr);
`endif
  end

  // Lowest-index pending port claims each free bank; its row is what that bank reads this cycle.
  always_comb begin
    win_valid = '0;
    for (int b = 0; b < NBANK; b++) win_row[b] = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (eff_pend[p] && !bank_busy[port_bank[p]] && !win_valid[port_bank[p]]) begin
        win_valid[port_bank[p]] = 1'b1;
        win_row[port_bank[p]]   = port_row[p];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) bank_rdata[b] = mem[b][win_row[b]];
  end

  always_comb begin
    served = '0;
    for (int p = 0; p < NPORT; p++) begin
      served[p] = fwd[p] ||
                  (eff_pend[p] && win_valid[port_bank[p]] && (port_row[p] == win_row[port_bank[p]]));
      served_data[p] = fwd[p] ? i_writeData : bank_rdata[port_bank[p]];
    end
    remaining = eff_pend & ~served;
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge i_fire) begin
    if (write_en) mem[wr_bank][wr_row] <= i_writeData;
  end

  always_ff @(posedge i_fire or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (accept) addr_q <= i_readAddr;
      for (int p = 0; p < NPORT; p++)
        if (served[p]) data_q[p*WIDTH +: WIDTH] <= served_data[p];
    end
  end

  always_ff @(posedge i_fire or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= '0;
      rsp_valid_q <= 1'b0;
      conflict_q  <= '0;
    end else begin
      if (state == SERVE && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
      if (accept || state == SERVE) begin
        pending <= remaining;
        if (remaining == '0) begin
          state       <= DONE;
          rsp_valid_q <= 1'b1;
        end else begin
          state       <= SERVE;
          rsp_valid_q <= 1'b0;
        end
      end else if (state == DONE && i_rsp_ready) begin
        state       <= IDLE;
        rsp_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_banked_read_sram.sv
// Randomized scoreboard bench for banked_read_sram; the reference model resolves each bundle
// as a sequence of service cycles over an address-level memory image.
module tb_banked_read_sram;
  localparam int NPORT = 4;
  localparam int NBANK = 8;
  localparam int WIDTH = 72;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic                   i_fire = 1'b0;
  logic                   rst;
  logic                   write_en;
  logic [AW-1:0]          i_writeAddr;
  logic [WIDTH-1:0]       i_writeData;
  logic                   i_req_valid;
  logic                   o_req_ready;
  logic [NPORT*AW-1:0]    i_readAddr;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [NPORT*WIDTH-1:0] o_datas;
  logic [15:0]            o_conflict_cnt;

  always #5 i_fire = ~i_fire;

  banked_read_sram #(.NPORT(NPORT), .NBANK(NBANK), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_fire(i_fire), .rst(rst), .write_en(write_en), .i_writeAddr(i_writeAddr),
    .i_writeData(i_writeData), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_readAddr(i_readAddr), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_datas(o_datas), .o_conflict_cnt(o_conflict_cnt)
  );

  typedef struct {
    logic [NPORT*WIDTH-1:0] data;
    int                     acc;
    int                     ncyc;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  int               exp_cnt = 0;
  int               rsp_mode = 2;
  logic [WIDTH-1:0] mdl_mem [DEPTH];
  logic [AW-1:0]    cur_addr [NPORT];
  bit               plan_we [NPORT];
  logic [AW-1:0]    plan_addr [NPORT];
  logic [WIDTH-1:0] plan_data [NPORT];

  always @(posedge i_fire) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [NPORT*WIDTH-1:0] act,
                             input logic [NPORT*WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Each loop pass is one service cycle: a bank being written is skipped, every other bank
  // reads the address of its lowest pending port and hands it to all ports wanting that address.
  task automatic modelBundle(output logic [NPORT*WIDTH-1:0] exp, output int ncyc);
    bit               pend [NPORT];
    bit               hit [NPORT];
    int               left;
    int               first;
    bit               we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    exp  = '0;
    ncyc = 0;
    left = NPORT;
    for (int p = 0; p < NPORT; p++) pend[p] = 1'b1;
    while (left > 0) begin
      if (ncyc < NPORT) begin
        we = plan_we[ncyc]; wa = plan_addr[ncyc]; wd = plan_data[ncyc];
      end else begin
        we = 1'b0; wa = '0; wd = '0;
      end
      for (int p = 0; p < NPORT; p++) hit[p] = 1'b0;
`ifdef BANKSRAM_WRITE_BYPASS_EN
      for (int p = 0; p < NPORT; p++)
        if (pend[p] && we && cur_addr[p] == wa) begin
          hit[p] = 1'b1;
          exp[p*WIDTH +: WIDTH] = wd;
        end
`endif
      for (int b = 0; b < NBANK; b++) begin
        first = -1;
        if (!(we && (int'(wa) % NBANK) == b))
          for (int p = 0; p < NPORT; p++)
            if (first < 0 && pend[p] && (int'(cur_addr[p]) % NBANK) == b) first = p;
        if (first >= 0)
          for (int p = 0; p < NPORT; p++)
            if (pend[p] && cur_addr[p] == cur_addr[first]) begin
              hit[p] = 1'b1;
              exp[p*WIDTH +: WIDTH] = mdl_mem[cur_addr[p]];
            end
      end
      for (int p = 0; p < NPORT; p++)
        if (hit[p]) begin
          pend[p] = 1'b0;
          left--;
        end
      if (we) mdl_mem[wa] = wd;
      ncyc++;
    end
  endtask

  task automatic driveWrite(input int k);
    if (k < NPORT && plan_we[k]) begin
      write_en    = 1'b1;
      i_writeAddr = plan_addr[k];
      i_writeData = plan_data[k];
    end else begin
      write_en = 1'b0;
    end
  endtask

  task automatic clearPlan();
    for (int k = 0; k < NPORT; k++) begin
      plan_we[k] = 1'b0; plan_addr[k] = '0; plan_data[k] = '0;
    end
  endtask

  task automatic setAddrs(input int a0, input int a1, input int a2, input int a3);
    cur_addr[0] = AW'(a0); cur_addr[1] = AW'(a1); cur_addr[2] = AW'(a2); cur_addr[3] = AW'(a3);
  endtask

  // Called at a falling edge; issues cur_addr with the planned writes and queues the expectation.
  task automatic applyStimulus();
    exp_t e;
    int   guard = 0;
    while (!o_req_ready && guard < 200) begin
      @(negedge i_fire);
      guard++;
    end
    if (!o_req_ready) begin
      checkOutput("req_ready_timeout", o_req_ready, 1);
      return;
    end
    modelBundle(e.data, e.ncyc);
    e.acc = cyc;
    sb.push_back(e);
    i_req_valid = 1'b1;
    for (int p = 0; p < NPORT; p++) i_readAddr[p*AW +: AW] = cur_addr[p];
    driveWrite(0);
    for (int k = 1; k < e.ncyc; k++) begin
      @(negedge i_fire);
      i_req_valid = 1'b0;
      driveWrite(k);
    end
    @(negedge i_fire);
    i_req_valid = 1'b0;
    write_en    = 1'b0;
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge i_fire);
      guard++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  initial begin
    i_rsp_ready = 1'b0;
    forever begin
      @(posedge i_fire);
      #2;
      case (rsp_mode)
        0:       i_rsp_ready = ($urandom_range(0, 3) != 0);
        1:       i_rsp_ready = 1'b0;
        default: i_rsp_ready = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    bit seen = 1'b0;
    forever begin
      @(negedge i_fire);
      if (!rst) begin
        seen = 1'b0;
      end else if (o_rsp_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", o_rsp_valid, 0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            checkOutput("latency", cyc - sb[0].acc, sb[0].ncyc);
            exp_cnt = (exp_cnt + sb[0].ncyc - 1 > 65535) ? 65535 : exp_cnt + sb[0].ncyc - 1;
            checkOutput("conflict_cnt", o_conflict_cnt, exp_cnt);
          end
          checkOutput("rsp_data", o_datas, sb[0].data);
          if (i_rsp_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [95:0] r;
    rst = 1'b0; write_en = 1'b0; i_writeAddr = '0; i_writeData = '0;
    i_req_valid = 1'b0; i_readAddr = '0;
    clearPlan();
    repeat (3) @(negedge i_fire);
    checkOutput("reset_rsp_valid", o_rsp_valid, 0);
    checkOutput("reset_datas", o_datas, 0);
    checkOutput("reset_cnt", o_conflict_cnt, 0);
    rst = 1'b1;
    @(negedge i_fire);
    checkOutput("reset_req_ready", o_req_ready, 1);

    for (int a = 0; a < DEPTH; a++) begin
      write_en = 1'b1; i_writeAddr = AW'(a); i_writeData = WIDTH'(32'h100 + a);
      mdl_mem[a] = WIDTH'(32'h100 + a);
      @(negedge i_fire);
    end
    write_en = 1'b0;

    $display("[TB] directed bundles");
    setAddrs(0, 1, 2, 3);     applyStimulus();
    setAddrs(0, 8, 16, 24);   applyStimulus();
    setAddrs(5, 5, 13, 5);    applyStimulus();
    setAddrs(3, 1, 2, 4);
    plan_we[0] = 1'b1; plan_addr[0] = AW'(3); plan_data[0] = WIDTH'(32'hABC);
    applyStimulus();
    clearPlan();
    waitDrain();

    $display("[TB] held response and back-to-back accept");
    rsp_mode = 1;
    setAddrs(0, 1, 2, 3);
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", o_rsp_valid, 1);
      checkOutput("hold_req_ready", o_req_ready, 0);
      @(negedge i_fire);
    end
    rsp_mode = 2;
    for (int g = 0; g < 10 && !o_req_ready; g++) @(negedge i_fire);
    checkOutput("b2b_rsp_valid", o_rsp_valid, 1);
    setAddrs(6, 7, 14, 22);
    applyStimulus();
    waitDrain();

    $display("[TB] randomized bundles");
    rsp_mode = 0;
    for (int it = 0; it < 80; it++) begin
      for (int p = 0; p < NPORT; p++) begin
        cur_addr[p] = AW'($urandom_range(0, 31));
        if (p > 0 && $urandom_range(0, 3) == 0) cur_addr[p] = cur_addr[0];
      end
      for (int k = 0; k < NPORT; k++) begin
        plan_we[k]   = ($urandom_range(0, 2) == 0);
        plan_addr[k] = ($urandom_range(0, 1) == 0) ? cur_addr[$urandom_range(0, NPORT-1)]
                                                   : AW'($urandom_range(0, 31));
        r = {$urandom, $urandom, $urandom};
        plan_data[k] = r[WIDTH-1:0];
      end
      applyStimulus();
    end
    clearPlan();
    waitDrain();

    $display("[TB] reset during service");
    rsp_mode = 2;
    for (int g = 0; g < 10 && !o_req_ready; g++) @(negedge i_fire);
    setAddrs(0, 8, 16, 24);
    i_req_valid = 1'b1;
    for (int p = 0; p < NPORT; p++) i_readAddr[p*AW +: AW] = cur_addr[p];
    @(negedge i_fire);
    i_req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    exp_cnt = 0;
    checkOutput("rst_rsp_valid", o_rsp_valid, 0);
    checkOutput("rst_datas", o_datas, 0);
    checkOutput("rst_cnt", o_conflict_cnt, 0);
    checkOutput("rst_req_ready", o_req_ready, 1);
    repeat (2) @(negedge i_fire);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_fire);
      checkOutput("post_rst_no_rsp", o_rsp_valid, 0);
    end
    setAddrs(0, 8, 1, 2);
    applyStimulus();
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/banked_read_sram.md
BANKED_READ_SRAM -- requirements
Module: banked_read_sram

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, meaning the number of read ports.
REQ-002 The block SHALL have parameter NBANK, default 8 (power of 2, at least 2), meaning the number of SRAM banks; bank = addr % NBANK, row = addr / NBANK.
REQ-003 The block SHALL have parameter WIDTH, default 72, meaning data bits per word.
REQ-004 The block SHALL have parameter DEPTH, default 256 (multiple of NBANK), meaning total words; AW = clog2(DEPTH).
REQ-005 The block SHALL have port i_fire, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port write_en, input, 1 bit: write strobe.
REQ-008 The block SHALL have port i_writeAddr, input, AW bits: write address.
REQ-009 The block SHALL have port i_writeData, input, WIDTH bits: write data.
REQ-010 The block SHALL have port i_req_valid, input, 1 bit: read bundle valid.
REQ-011 The block SHALL have port o_req_ready, output, 1 bit: bundle accepted when valid and ready are both high at an edge.
REQ-012 The block SHALL have port i_readAddr, input, NPORT*AW bits: port p uses bits [p*AW +: AW].
REQ-013 The block SHALL have port o_rsp_valid, output, 1 bit: response bundle valid.
REQ-014 The block SHALL have port i_rsp_ready, input, 1 bit: response consumed when valid and ready are both high.
REQ-015 The block SHALL have port o_datas, output, NPORT*WIDTH bits: port p data at bits [p*WIDTH +: WIDTH].
REQ-016 The block SHALL have port o_conflict_cnt, output, 16 bits: saturating count of extra service cycles caused by conflicts.

Function
REQ-017 o_req_ready SHALL be high exactly when state is IDLE, or when state is DONE and i_rsp_ready is high.
REQ-018 The state machine SHALL have three states: IDLE, SERVE and DONE.
REQ-019 Bundle acceptance SHALL latch all NPORT addresses, set every pending bit, and enter SERVE; servicing begins in the acceptance cycle itself.
REQ-020 In each service cycle, for each bank, the lowest-index pending port SHALL win, and every other pending port with the same bank and same row SHALL be served in the same cycle (broadcast).
REQ-021 Pending ports that lose arbitration SHALL remain pending for the next cycle; each service cycle after the first SHALL increment o_conflict_cnt, saturating at 0xFFFF.
REQ-022 Served data SHALL be registered into the port's o_datas slot at the edge ending the service cycle; read latency is 1 cycle with no conflict.
REQ-023 When the last pending bit clears, the state SHALL go to DONE and o_rsp_valid SHALL be high; o_datas SHALL hold stable until i_rsp_ready.
REQ-024 In DONE with i_rsp_ready high and i_req_valid high, the new bundle SHALL be accepted in the same cycle (back-to-back); with i_req_valid low, the state SHALL go to IDLE.
REQ-025 With a conflict-free bundle, the bench SHALL observe o_rsp_valid one cycle after acceptance; worst case (all ports in one bank, distinct rows) SHALL be NPORT cycles.
REQ-026 A write SHALL be accepted in any state and SHALL commit at the edge.
REQ-027 The written bank SHALL be unavailable to reads that cycle; pending reads to that bank SHALL be deferred, and the deferral SHALL count as a conflict cycle.
REQ-028 Reads SHALL not stall writes.
REQ-029 Array contents SHALL not be reset; a read of an unwritten location SHALL return X in simulation.

Reset
REQ-030 While rst is low, the following SHALL hold asynchronously: state IDLE, pending bits 0, o_rsp_valid 0, o_datas 0, o_conflict_cnt 0, o_req_ready 1 after deassertion.
REQ-031 Reset asserted mid-SERVE or mid-DONE SHALL discard the in-flight bundle with no response.

Configuration
REQ-032 With macro BANKSRAM_WRITE_BYPASS_EN defined, a pending read whose address equals i_writeAddr in a write cycle SHALL be served that cycle with i_writeData, without deferral and without counting a conflict.
REQ-033 Without BANKSRAM_WRITE_BYPASS_EN, that read SHALL be deferred per REQ-027 and SHALL return the new data one cycle later.

Verification
REQ-034 The bench SHALL cover: write 0..7 with data 0x100+a, then read {0,1,2,3} -> o_rsp_valid at acceptance+1, data 0x100..0x103, o_conflict_cnt 0.
REQ-035 The bench SHALL cover: read {0,8,16,24}, all in bank 0 -> 4 service cycles, o_rsp_valid at acceptance+4, o_conflict_cnt +3.
REQ-036 The bench SHALL cover: read {5,5,13,5} -> 2 cycles; ports 0, 1 and 3 broadcast in the first cycle, port 2 in the second; o_conflict_cnt +1.
REQ-037 The bench SHALL cover: read {3,...} with a same-cycle write to 3 of 0xABC -> with the macro, 1-cycle latency and data 0xABC; without it, 2 cycles and data 0xABC.
REQ-038 The bench SHALL cover: i_rsp_ready held low 5 cycles -> o_datas stable and o_req_ready low; on release with i_req_valid high, the next bundle is accepted in the same cycle.
REQ-039 The bench SHALL cover: rst pulsed low during SERVE -> outputs 0 immediately, and no o_rsp_valid after release.
